// File: rtl/pdm_multi.sv
// Multi-channel first-order PDM DAC driver: a double-buffered frame is loaded once per OSR clocks.
// Optional sticky underrun flag is enabled with `define PDM_MULTI_UNDERRUN_EN.

module pdm_lane #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic [INPUT_WIDTH-1:0]  active,
   output logic [OUTPUT_WIDTH-1:0] dac
);
   localparam int L = INPUT_WIDTH - OUTPUT_WIDTH;

   logic [L-1:0]           acc;
   logic [INPUT_WIDTH:0]   sum;
   logic [OUTPUT_WIDTH:0]  hi;

   assign sum = {1'b0, active} + {{(OUTPUT_WIDTH+1){1'b0}}, acc};
   assign hi  = sum[INPUT_WIDTH:L];

   // A disabled lane restarts from acc=0 so re-enable is deterministic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
         dac <= '0;
      end else if (!en) begin
         acc <= '0;
         dac <= '0;
      end else begin
         acc <= sum[L-1:0];
         dac <= hi[OUTPUT_WIDTH] ? {OUTPUT_WIDTH{1'b1}} : hi[OUTPUT_WIDTH-1:0];
      end
   end
endmodule

module pdm_multi #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 2,
   parameter int NUM_CHANNELS = 2,
   parameter int OSR          = 64
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0]  s_data,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [NUM_CHANNELS-1:0]              ch_en,
   input  logic                                 clr_underrun,
   output logic [NUM_CHANNELS*OUTPUT_WIDTH-1:0] dac_out,
   output logic                                 tick,
   output logic                                 underrun
);
   localparam int CW = (OSR > 2) ? $clog2(OSR) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);

   logic [CW-1:0]                                cnt, cnt_nxt;
   logic                                         hold_full;
   logic                                         xfer;
   logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0]     hold_q;
   logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0]     active_q;
   logic [NUM_CHANNELS-1:0][OUTPUT_WIDTH-1:0]    dac_lane;

   assign cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
   assign s_ready = !hold_full || tick;
   assign xfer    = s_valid && s_ready;
   assign dac_out = dac_lane;

   // tick is registered alongside the counter so it is high exactly while cnt == OSR-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (cnt_nxt == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_full <= 1'b0;
         hold_q    <= '0;
         active_q  <= '0;
      end else begin
         // On a tick the held frame is consumed, so the slot is free unless refilled now.
         hold_full <= xfer || (hold_full && !tick);
         if (xfer)
            hold_q <= s_data;
         if (tick && hold_full)
            active_q <= hold_q;
      end
   end

`ifdef PDM_MULTI_UNDERRUN_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         underrun <= 1'b0;
      else if (tick && !hold_full)
         underrun <= 1'b1;
      else if (clr_underrun)
         underrun <= 1'b0;
   end
`else
   assign underrun = 1'b0;
   logic unused_clr;
   assign unused_clr = clr_underrun;
`endif

   genvar k;
   generate
      for (k = 0; k < NUM_CHANNELS; k++) begin : g_lane
         pdm_lane #(
            .INPUT_WIDTH  (INPUT_WIDTH),
            .OUTPUT_WIDTH (OUTPUT_WIDTH)
         ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (ch_en[k]),
            .active  (active_q[k]),
            .dac     (dac_lane[k])
         );
      end
   endgenerate
endmodule

// File: tb/tb_pdm_multi.sv
// Self-checking bench for pdm_multi: directed scenarios plus random traffic against a
// cycle-count / frame-queue reference model.

module tb_pdm_multi;
   localparam int IW   = 5;
   localparam int OW   = 2;
   localparam int NC   = 2;
   localparam int OSR  = 4;
   localparam int L    = IW - OW;
   localparam int DMAX = (1 << OW) - 1;
`ifdef PDM_MULTI_UNDERRUN_EN
   localparam bit UR_EN = 1'b1;
`else
   localparam bit UR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NC*IW-1:0]  s_data;
   logic              s_valid;
   logic              s_ready;
   logic [NC-1:0]     ch_en;
   logic              clr_underrun;
   logic [NC*OW-1:0]  dac_out;
   logic              tick;
   logic              underrun;

   pdm_multi #(
      .INPUT_WIDTH  (IW),
      .OUTPUT_WIDTH (OW),
      .NUM_CHANNELS (NC),
      .OSR          (OSR)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .ch_en        (ch_en),
      .clr_underrun (clr_underrun),
      .dac_out      (dac_out),
      .tick         (tick),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // Reference model: cycles since reset, a queue of pending frames, per-channel integers.
   int                m_cyc;
   logic [NC*IW-1:0]  m_hold[$];
   int                m_act [NC];
   int                m_acc [NC];
   int                m_dac [NC];
   bit                m_under;
   int                win0, win1;

   function automatic void model_reset();
      m_cyc = 0;
      m_hold.delete();
      for (int k = 0; k < NC; k++) begin
         m_act[k] = 0; m_acc[k] = 0; m_dac[k] = 0;
      end
      m_under = 1'b0;
   endfunction

   task automatic check1(input string tag, input logic obs, input logic exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s obs=%0b exp=%0b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check s_ready pre-edge, advance model, then check registered outputs.
   task automatic step();
      bit                tk, rdy, xf;
      int                s;
      logic [NC*IW-1:0]  f;
      logic [NC*OW-1:0]  exp_dac;
      tk  = (m_cyc % OSR) == OSR - 1;
      rdy = (m_hold.size() == 0) || tk;
      check1("s_ready", s_ready, rdy);
      xf = s_valid && rdy;
      for (int k = 0; k < NC; k++) begin
         if (ch_en[k]) begin
            s = m_act[k] + m_acc[k];
            m_dac[k] = (s >> L) > DMAX ? DMAX : (s >> L);
            m_acc[k] = s % (1 << L);
         end else begin
            m_dac[k] = 0;
            m_acc[k] = 0;
         end
      end
      if (tk && m_hold.size() == 0) begin
         if (UR_EN) m_under = 1'b1;
      end else if (clr_underrun && UR_EN) begin
         m_under = 1'b0;
      end
      if (tk && m_hold.size() != 0) begin
         f = m_hold.pop_front();
         for (int k = 0; k < NC; k++) m_act[k] = int'(f[k*IW +: IW]);
      end
      if (xf) m_hold.push_back(s_data);
      m_cyc++;
      @(posedge clk); #1;
      for (int k = 0; k < NC; k++) exp_dac[k*OW +: OW] = OW'(m_dac[k]);
      nchk++;
      assert (dac_out === exp_dac) else begin
         nerr++;
         $error("FAIL dac_out obs=%b exp=%b t=%0t", dac_out, exp_dac, $time);
      end
      check1("tick", tick, (m_cyc % OSR) == OSR - 1);
      check1("underrun", underrun, m_under);
      win0 += int'(dac_out[0 +: OW]);
      win1 += int'(dac_out[OW +: OW]);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_int("rst_dac", int'(dac_out), 0);
      check1("rst_tick", tick, 1'b0);
      check1("rst_s_ready", s_ready, 1'b1);
      check1("rst_underrun", underrun, 1'b0);
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check1("rst_hold_s_ready", s_ready, 1'b1);
      reset_n = 1'b1;
   endtask

   initial begin
      s_data = '0; s_valid = 1'b0; ch_en = 2'b11; clr_underrun = 1'b0;
      win0 = 0; win1 = 0;
      @(posedge clk); #1;
      do_reset();

      // First tick: cycles 0..2 low, cycle 3 high (model checks tick every cycle).
      s_data = {5'd15, 5'd1}; s_valid = 1'b1;
      run(12);
      win0 = 0; win1 = 0; run(16);
      check_int("ch0_s1_mean", win0, 2);
      check_int("ch1_s15_mean", win1, 30);

      // Saturation on ch1.
      s_data = {5'd31, 5'd1};
      run(12);
      win0 = 0; win1 = 0; run(16);
      check_int("ch1_sat", win1, 16 * DMAX);
      check_int("ch0_s1_mean2", win0, 2);

      // ch1 disabled, both samples 15.
      s_data = {5'd15, 5'd15}; ch_en = 2'b01;
      run(12);
      win0 = 0; win1 = 0; run(16);
      check_int("ch0_en_mean", win0, 30);
      check_int("ch1_dis_zero", win1, 0);

      // Starve the input: active repeats and underrun latches.
      ch_en = 2'b11; s_valid = 1'b0;
      run(12);
      check1("underrun_set", underrun, UR_EN);
      win0 = 0; win1 = 0; run(16);
      check_int("repeat_ch0", win0, 30);
      check_int("repeat_ch1", win1, 30);
      s_valid = 1'b1; s_data = {5'd7, 5'd3};
      run(8);
      clr_underrun = 1'b1; run(1); clr_underrun = 1'b0;
      check1("underrun_clr", underrun, 1'b0);
      run(8);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         s_valid      = ($urandom_range(0, 3) != 0);
         s_data       = NC*IW'($urandom);
         ch_en        = NC'($urandom);
         clr_underrun = ($urandom_range(0, 7) == 0);
         step();
      end

      // A frame accepted just before a mid-operation reset is discarded.
      ch_en = 2'b11; clr_underrun = 1'b0;
      s_valid = 1'b1; s_data = {5'd20, 5'd20};
      run(2);
      do_reset();
      s_valid = 1'b0;
      win0 = 0; win1 = 0; run(12);
      check_int("post_rst_ch0", win0, 0);
      check_int("post_rst_ch1", win1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
